// File: rtl/aer_transmitter.sv
// ---------------------------------------------------------------------------
// aer_transmitter
//
// Sender side of an AER link. Each accepted pixel event is sent as a row
// word (xsel=0, aer=ev_y) followed by a column word (xsel=1, aer={ev_x,ev_pol}),
// each using a 4-phase req/ack handshake. A repeated row can be suppressed
// when it matches the last acknowledged row.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ev_valid     event available
//   ev_ready     event accepted on ev_valid & ev_ready
//   ev_y         row address          [AER_W-1:0]
//   ev_x         column address       [AER_W-2:0]
//   ev_pol       polarity
//   aer          AER address bus      [AER_W-1:0] (registered)
//   xsel         0 = row word, 1 = column word (registered)
//   req          AER request (registered)
//   ack          AER acknowledge, asynchronous
//   busy         FSM not idle
//   timeout_err  sticky ack-timeout flag
//   err_clr      clears timeout_err (a same-cycle set wins)
//   ev_count     events fully sent, wraps   [CNT_W-1:0]
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for an event; ev_ready high (unless ack_s is high)
// ROW_SETUP | row word on aer, holding setup time before req
// ROW_REQ   | req high, waiting for ack_s=1
// ROW_REL   | req low, waiting for ack_s=0
// COL_SETUP | column word on aer, holding setup time before req
// COL_REQ   | req high, waiting for ack_s=1
// COL_REL   | req low, waiting for ack_s=0; exit counts the event
// DRAIN     | after a timeout, req low, waiting for ack_s=0 (no timeout)
// ---------------------------------------------------------------------------
module aer_transmitter #(
   parameter int AER_W           = 10,
   parameter int SYNC_STAGES     = 2,
   parameter int SETUP_CYCLES    = 1,
   parameter int ACK_TIMEOUT     = 1023,
   parameter int SKIP_REPEAT_ROW = 1,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ev_valid,
   output logic             ev_ready,
   input  logic [AER_W-1:0] ev_y,
   input  logic [AER_W-2:0] ev_x,
   input  logic             ev_pol,
   output logic [AER_W-1:0] aer,
   output logic             xsel,
   output logic             req,
   input  logic             ack,
   output logic             busy,
   output logic             timeout_err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] ev_count
);

   localparam int SET_W  = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
   localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [SET_W-1:0]  SETUP_LOAD = SET_W'(SETUP_CYCLES - 1);
   localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ROW_SETUP,
      S_ROW_REQ,
      S_ROW_REL,
      S_COL_SETUP,
      S_COL_REQ,
      S_COL_REL,
      S_DRAIN
   } state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_ack_sync;
   logic [AER_W-1:0]       r_aer;
   logic                   r_xsel;
   logic                   r_req;
   logic                   r_timeout_err;
   logic [CNT_W-1:0]       r_count;
   logic [AER_W-1:0]       r_y;
   logic [AER_W-2:0]       r_x;
   logic                   r_pol;
   logic [AER_W-1:0]       r_last_row;
   logic                   r_row_vld;
   logic [SET_W-1:0]       r_set_cnt;
   logic [WAIT_W-1:0]      r_wait;

   logic w_ack_s;
   logic w_ev_ready;
   logic w_accept;
   logic w_skip_row;
   logic w_in_wait;
   logic w_ack_done;
   logic w_abort;

   assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

   // Refusing events while ack_s is still high keeps a stuck or late
   // acknowledge from being mistaken for the first handshake of a new event.
   assign w_ev_ready = (r_state == S_IDLE) && rst_n && !w_ack_s;
   assign w_accept   = ev_valid && w_ev_ready;
   assign w_skip_row = (SKIP_REPEAT_ROW != 0) && r_row_vld && (ev_y == r_last_row);

   // The REQ states wait for ack_s to rise, the REL states for it to fall.
   assign w_in_wait  = (r_state == S_ROW_REQ) || (r_state == S_ROW_REL) ||
                       (r_state == S_COL_REQ) || (r_state == S_COL_REL);
   assign w_ack_done = ((r_state == S_ROW_REQ) || (r_state == S_COL_REQ)) ? w_ack_s : !w_ack_s;
   assign w_abort    = w_in_wait && !w_ack_done && (r_wait == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack_sync <= '0;
      end else begin
         r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_aer         <= '0;
         r_xsel        <= 1'b0;
         r_req         <= 1'b0;
         r_timeout_err <= 1'b0;
         r_count       <= '0;
         r_y           <= '0;
         r_x           <= '0;
         r_pol         <= 1'b0;
         r_last_row    <= '0;
         r_row_vld     <= 1'b0;
         r_set_cnt     <= '0;
         r_wait        <= '0;
      end else begin
         // The abort branch below assigns later, so a timeout in the same
         // cycle overrides the clear.
         if (err_clr) begin
            r_timeout_err <= 1'b0;
         end

         if (w_abort) begin
            r_req         <= 1'b0;
            r_timeout_err <= 1'b1;
            r_row_vld     <= 1'b0;
            r_state       <= S_DRAIN;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept) begin
                     r_y       <= ev_y;
                     r_x       <= ev_x;
                     r_pol     <= ev_pol;
                     r_set_cnt <= SETUP_LOAD;
                     if (w_skip_row) begin
                        r_aer   <= {ev_x, ev_pol};
                        r_xsel  <= 1'b1;
                        r_state <= S_COL_SETUP;
                     end else begin
                        r_aer   <= ev_y;
                        r_xsel  <= 1'b0;
                        r_state <= S_ROW_SETUP;
                     end
                  end
               end

               S_ROW_SETUP: begin
                  if (r_set_cnt == '0) begin
                     r_req   <= 1'b1;
                     r_wait  <= WAIT_LOAD;
                     r_state <= S_ROW_REQ;
                  end else begin
                     r_set_cnt <= r_set_cnt - SET_W'(1);
                  end
               end

               S_ROW_REQ: begin
                  if (w_ack_s) begin
                     r_req   <= 1'b0;
                     r_wait  <= WAIT_LOAD;
                     r_state <= S_ROW_REL;
                  end else begin
                     r_wait <= r_wait - WAIT_W'(1);
                  end
               end

               S_ROW_REL: begin
                  if (!w_ack_s) begin
                     r_aer      <= {r_x, r_pol};
                     r_xsel     <= 1'b1;
                     r_last_row <= r_y;
                     r_row_vld  <= 1'b1;
                     r_set_cnt  <= SETUP_LOAD;
                     r_state    <= S_COL_SETUP;
                  end else begin
                     r_wait <= r_wait - WAIT_W'(1);
                  end
               end

               S_COL_SETUP: begin
                  if (r_set_cnt == '0) begin
                     r_req   <= 1'b1;
                     r_wait  <= WAIT_LOAD;
                     r_state <= S_COL_REQ;
                  end else begin
                     r_set_cnt <= r_set_cnt - SET_W'(1);
                  end
               end

               S_COL_REQ: begin
                  if (w_ack_s) begin
                     r_req   <= 1'b0;
                     r_wait  <= WAIT_LOAD;
                     r_state <= S_COL_REL;
                  end else begin
                     r_wait <= r_wait - WAIT_W'(1);
                  end
               end

               S_COL_REL: begin
                  if (!w_ack_s) begin
                     r_count <= r_count + CNT_W'(1);
                     r_state <= S_IDLE;
                  end else begin
                     r_wait <= r_wait - WAIT_W'(1);
                  end
               end

               S_DRAIN: begin
                  if (!w_ack_s) begin
                     r_state <= S_IDLE;
                  end
               end

               default: begin
                  r_req   <= 1'b0;
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign ev_ready    = w_ev_ready;
   assign aer         = r_aer;
   assign xsel        = r_xsel;
   assign req         = r_req;
   assign busy        = (r_state != S_IDLE);
   assign timeout_err = r_timeout_err;
   assign ev_count    = r_count;

endmodule

// File: tb/tb_aer_transmitter.sv
// ---------------------------------------------------------------------------
// tb_aer_transmitter
//
// Two transmitters share clk/rst_n:
//   u_dut_a : SETUP_CYCLES=1, ACK_TIMEOUT=15, row skipping on, 4-bit counter
//   u_dut_b : SETUP_CYCLES=2, ACK_TIMEOUT=40, row skipping off, SYNC_STAGES=3
// Each has an ack responder and a word scoreboard fed when events are driven.
// ---------------------------------------------------------------------------
module tb_aer_transmitter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       a_ev_valid, a_ev_ready, a_ev_pol, a_ack, a_req, a_xsel, a_busy, a_terr, a_err_clr;
   logic [9:0] a_ev_y, a_aer;
   logic [8:0] a_ev_x;
   logic [3:0] a_cnt;

   logic        b_ev_valid, b_ev_ready, b_ev_pol, b_ack, b_req, b_xsel, b_busy, b_terr, b_err_clr;
   logic [9:0]  b_ev_y, b_aer;
   logic [8:0]  b_ev_x;
   logic [15:0] b_cnt;

   aer_transmitter #(
      .AER_W(10), .SYNC_STAGES(2), .SETUP_CYCLES(1), .ACK_TIMEOUT(15),
      .SKIP_REPEAT_ROW(1), .CNT_W(4)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .ev_valid(a_ev_valid), .ev_ready(a_ev_ready),
      .ev_y(a_ev_y), .ev_x(a_ev_x), .ev_pol(a_ev_pol), .aer(a_aer), .xsel(a_xsel),
      .req(a_req), .ack(a_ack), .busy(a_busy), .timeout_err(a_terr),
      .err_clr(a_err_clr), .ev_count(a_cnt)
   );

   aer_transmitter #(
      .AER_W(10), .SYNC_STAGES(3), .SETUP_CYCLES(2), .ACK_TIMEOUT(40),
      .SKIP_REPEAT_ROW(0), .CNT_W(16)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .ev_valid(b_ev_valid), .ev_ready(b_ev_ready),
      .ev_y(b_ev_y), .ev_x(b_ev_x), .ev_pol(b_ev_pol), .aer(b_aer), .xsel(b_xsel),
      .req(b_req), .ack(b_ack), .busy(b_busy), .timeout_err(b_terr),
      .err_clr(b_err_clr), .ev_count(b_cnt)
   );

   int checks = 0;
   int failures = 0;

   logic [10:0] q_a[$];
   logic [10:0] q_b[$];

   int a_delay = 3;
   int b_delay = 3;
   bit a_tie0  = 1'b0;
   int a_rcnt  = 0;
   int b_rcnt  = 0;
   int a_rises = 0;
   int b_rises = 0;

   bit          ma_vld = 1'b0;
   logic [9:0]  ma_last = '0;
   logic [3:0]  ma_cnt = '0;
   logic [15:0] mb_cnt = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Responders: ack rises a set number of cycles after req is seen high,
   // and falls once req is low.
   always @(negedge clk) begin
      if (!rst_n) begin
         a_ack  = 1'b0;
         a_rcnt = 0;
      end else if (a_req && !a_ack && !a_tie0) begin
         a_rcnt++;
         if (a_rcnt >= a_delay) a_ack = 1'b1;
      end else if (!a_req) begin
         a_ack  = 1'b0;
         a_rcnt = 0;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         b_ack  = 1'b0;
         b_rcnt = 0;
      end else if (b_req && !b_ack) begin
         b_rcnt++;
         if (b_rcnt >= b_delay) b_ack = 1'b1;
      end else if (!b_req) begin
         b_ack  = 1'b0;
         b_rcnt = 0;
      end
   end

   // Monitors: each req rising edge pops the expected word; the word must
   // stay stable while req or ack is high.
   logic        a_prev_req = 1'b0, a_hold = 1'b0;
   logic [10:0] a_held = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         a_prev_req = 1'b0;
         a_hold     = 1'b0;
      end else begin
         if (a_req && !a_prev_req) begin
            a_rises++;
            if (q_a.size() == 0) chk("a_unexpected_word", 32'({a_xsel, a_aer}), 32'hFFFF_FFFF);
            else                 chk("a_word", 32'({a_xsel, a_aer}), 32'(q_a.pop_front()));
            a_held = {a_xsel, a_aer};
            a_hold = 1'b1;
         end else if (a_hold) begin
            if (a_req || a_ack) chk("a_word_stable", 32'({a_xsel, a_aer}), 32'(a_held));
            else                a_hold = 1'b0;
         end
         a_prev_req = a_req;
      end
   end

   logic        b_prev_req = 1'b0, b_hold = 1'b0;
   logic [10:0] b_held = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         b_prev_req = 1'b0;
         b_hold     = 1'b0;
      end else begin
         if (b_req && !b_prev_req) begin
            b_rises++;
            if (q_b.size() == 0) chk("b_unexpected_word", 32'({b_xsel, b_aer}), 32'hFFFF_FFFF);
            else                 chk("b_word", 32'({b_xsel, b_aer}), 32'(q_b.pop_front()));
            b_held = {b_xsel, b_aer};
            b_hold = 1'b1;
         end else if (b_hold) begin
            if (b_req || b_ack) chk("b_word_stable", 32'({b_xsel, b_aer}), 32'(b_held));
            else                b_hold = 1'b0;
         end
         b_prev_req = b_req;
      end
   end

   // Pushes the expected words, then handshakes the event in; returns #1
   // after the accepting edge with the inputs scrambled.
   task automatic send_a(input logic [9:0] y, input logic [8:0] x, input logic p, input bit to);
      bit skip;
      int n;
      skip = ma_vld && (y == ma_last);
      if (!skip) q_a.push_back({1'b0, y});
      if (skip || !to) q_a.push_back({1'b1, x, p});
      if (to) begin
         ma_vld = 1'b0;
      end else begin
         ma_vld  = 1'b1;
         ma_last = y;
         ma_cnt  = ma_cnt + 4'd1;
      end
      @(negedge clk);
      a_ev_valid = 1'b1;
      a_ev_y     = y;
      a_ev_x     = x;
      a_ev_pol   = p;
      n = 0;
      while (!a_ev_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("a_accept_wait", 32'(n < 100), 32'd1);
      @(posedge clk);
      #1;
      a_ev_valid = 1'b0;
      a_ev_y     = 10'($urandom);
      a_ev_x     = 9'($urandom);
      a_ev_pol   = 1'($urandom);
   endtask

   task automatic send_b(input logic [9:0] y, input logic [8:0] x, input logic p);
      int n;
      q_b.push_back({1'b0, y});
      q_b.push_back({1'b1, x, p});
      mb_cnt = mb_cnt + 16'd1;
      @(negedge clk);
      b_ev_valid = 1'b1;
      b_ev_y     = y;
      b_ev_x     = x;
      b_ev_pol   = p;
      n = 0;
      while (!b_ev_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("b_accept_wait", 32'(n < 100), 32'd1);
      @(posedge clk);
      #1;
      b_ev_valid = 1'b0;
   endtask

   task automatic wait_idle_a();
      int n = 0;
      @(negedge clk);
      while (a_busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("a_idle_wait", 32'(n < 400), 32'd1);
   endtask

   task automatic wait_idle_b();
      int n = 0;
      @(negedge clk);
      while (b_busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("b_idle_wait", 32'(n < 400), 32'd1);
   endtask

   task automatic wait_req_a();
      int n = 0;
      while (!a_req && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("a_req_wait", 32'(n < 40), 32'd1);
   endtask

   initial begin
      int n;
      int r0;
      rst_n      = 1'b0;
      a_ev_valid = 1'b0; a_ev_y = '0; a_ev_x = '0; a_ev_pol = 1'b0; a_err_clr = 1'b0;
      b_ev_valid = 1'b0; b_ev_y = '0; b_ev_x = '0; b_ev_pol = 1'b0; b_err_clr = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_aer", 32'(a_aer), 32'd0);
      chk("rst_xsel", 32'(a_xsel), 32'd0);
      chk("rst_req", 32'(a_req), 32'd0);
      chk("rst_terr", 32'(a_terr), 32'd0);
      chk("rst_cnt", 32'(a_cnt), 32'd0);
      chk("rst_ready_a", 32'(a_ev_ready), 32'd0);
      chk("rst_ready_b", 32'(b_ev_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(a_ev_ready), 32'd1);
      chk("busy_after_rst", 32'(a_busy), 32'd0);

      // Single event: timing of word and req
      send_a(10'd5, 9'd3, 1'b1, 1'b0);
      @(negedge clk);
      chk("t1_aer_cyc1", 32'(a_aer), 32'h005);
      chk("t1_xsel_cyc1", 32'(a_xsel), 32'd0);
      chk("t1_req_cyc1", 32'(a_req), 32'd0);
      chk("t1_ready_low", 32'(a_ev_ready), 32'd0);
      chk("t1_busy", 32'(a_busy), 32'd1);
      @(negedge clk);
      chk("t1_req_cyc2", 32'(a_req), 32'd1);
      chk("t1_aer_cyc2", 32'(a_aer), 32'h005);
      wait_idle_a();
      chk("t1_count", 32'(a_cnt), 32'(ma_cnt));
      chk("t1_col_word", 32'(a_aer), 32'h007);

      // Repeated row is skipped on A
      r0 = a_rises;
      send_a(10'd6, 9'd1, 1'b0, 1'b0);
      send_a(10'd6, 9'd2, 1'b1, 1'b0);
      wait_idle_a();
      chk("t2_a_pulses", 32'(a_rises - r0), 32'd3);
      chk("t2_a_count", 32'(a_cnt), 32'(ma_cnt));

      // Same pair on B sends the row word every time
      r0 = b_rises;
      send_b(10'd5, 9'd1, 1'b0);
      send_b(10'd5, 9'd2, 1'b0);
      wait_idle_b();
      chk("t2_b_pulses", 32'(b_rises - r0), 32'd4);
      chk("t2_b_count", 32'(b_cnt), 32'(mb_cnt));

      // Slow responder, ev_valid held high the whole time
      b_delay = 20;
      q_b.push_back({1'b0, 10'h12});
      q_b.push_back({1'b1, 9'h0AB, 1'b1});
      mb_cnt = mb_cnt + 16'd1;
      @(negedge clk);
      b_ev_valid = 1'b1;
      b_ev_y     = 10'h12;
      b_ev_x     = 9'h0AB;
      b_ev_pol   = 1'b1;
      n = 0;
      while (!b_ev_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t3_accept_wait", 32'(n < 100), 32'd1);
      @(posedge clk);
      #1;
      n = 0;
      @(negedge clk);
      while (b_busy && n < 500) begin
         chk("t3_ready_low", 32'(b_ev_ready), 32'd0);
         @(negedge clk);
         n++;
      end
      b_ev_valid = 1'b0;
      chk("t3_idle_wait", 32'(n < 500), 32'd1);
      chk("t3_slow", 32'(n > 40), 32'd1);
      chk("t3_count", 32'(b_cnt), 32'(mb_cnt));
      chk("t3_no_timeout", 32'(b_terr), 32'd0);
      b_delay = 3;

      // Ack never comes: timeout after 15 cycles of req
      a_tie0 = 1'b1;
      send_a(10'd7, 9'd4, 1'b1, 1'b1);
      wait_req_a();
      n = 0;
      while (a_req && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("t4_req_high_cycles", 32'(n), 32'd15);
      chk("t4_terr", 32'(a_terr), 32'd1);
      wait_idle_a();
      chk("t4_count_unchanged", 32'(a_cnt), 32'(ma_cnt));
      a_tie0 = 1'b0;
      send_a(10'd7, 9'd4, 1'b1, 1'b0);
      wait_idle_a();
      chk("t4_resend_count", 32'(a_cnt), 32'(ma_cnt));
      chk("t4_terr_sticky", 32'(a_terr), 32'd1);
      a_err_clr = 1'b1;
      @(negedge clk);
      a_err_clr = 1'b0;
      chk("t4_terr_cleared", 32'(a_terr), 32'd0);

      // Reset in the middle of a request
      send_a(10'd5, 9'd0, 1'b0, 1'b0);
      wait_req_a();
      rst_n = 1'b0;
      #1;
      chk("t5_req", 32'(a_req), 32'd0);
      chk("t5_aer", 32'(a_aer), 32'd0);
      chk("t5_xsel", 32'(a_xsel), 32'd0);
      chk("t5_cnt", 32'(a_cnt), 32'd0);
      chk("t5_ready", 32'(a_ev_ready), 32'd0);
      q_a.delete();
      ma_vld = 1'b0;
      ma_cnt = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_a(10'd5, 9'd1, 1'b1, 1'b0);
      wait_idle_a();
      chk("t5_after_count", 32'(a_cnt), 32'(ma_cnt));

      // err_clr in the timeout cycle loses to the set
      chk("t6_terr_before", 32'(a_terr), 32'd0);
      a_tie0 = 1'b1;
      send_a(10'd8, 9'd0, 1'b0, 1'b1);
      wait_req_a();
      for (int k = 1; k < 15; k++) @(negedge clk);
      chk("t6_req_before_to", 32'(a_req), 32'd1);
      a_err_clr = 1'b1;
      @(negedge clk);
      a_err_clr = 1'b0;
      chk("t6_req_after_to", 32'(a_req), 32'd0);
      chk("t6_terr_set_wins", 32'(a_terr), 32'd1);
      wait_idle_a();
      a_tie0 = 1'b0;
      chk("t6_count_unchanged", 32'(a_cnt), 32'(ma_cnt));

      // Counter wrap
      for (int i = 0; i < 14; i++) begin
         send_a(10'(20 + i / 2), 9'(i), 1'(i), 1'b0);
      end
      wait_idle_a();
      chk("t6_count_full", 32'(a_cnt), 32'hF);
      send_a(10'd40, 9'd9, 1'b1, 1'b0);
      wait_idle_a();
      chk("t6_count_wrap", 32'(a_cnt), 32'd0);
      chk("t6_model_wrap", 32'(a_cnt), 32'(ma_cnt));

      chk("q_a_empty", 32'(q_a.size()), 32'd0);
      chk("q_b_empty", 32'(q_b.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
